// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done
// handshake, runtime signed/unsigned mode and divide-by-zero detection.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   rem_reg, rem_next;
    logic [WIDTH-1:0]   quo_reg, quo_next;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dvs_reg, dvs_next;      // divisor magnitude
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic               dz_pend_reg, dz_pend_next; // zero divisor accepted, report next edge
    logic               done_reg, done_next;
    logic               dz_reg, dz_next;
    logic [WIDTH-1:0]   quotient_reg, quotient_next;
    logic [WIDTH-1:0]   remainder_reg, remainder_next;

    logic [WIDTH-1:0]   dividend_mag, divisor_mag;
    logic [WIDTH:0]     shifted, trial;

    // Operand magnitudes; negating the most negative value yields 2^(WIDTH-1) as unsigned.
    assign dividend_mag = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One restoring step: shift in next dividend bit, trial-subtract the divisor.
    assign shifted = {rem_reg, quo_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_reg};

    // Next-state and datapath logic.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        dvs_next       = dvs_reg;
        neg_q_next     = neg_q_reg;
        neg_r_next     = neg_r_reg;
        dz_pend_next   = 1'b0;
        done_next      = 1'b0;
        dz_next        = dz_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        case (state_reg)
            IDLE: begin
                // Divide-by-zero result; the raw dividend was parked in quo_reg.
                if (dz_pend_reg) begin
                    quotient_next  = '1;
                    remainder_next = quo_reg;
                    dz_next        = 1'b1;
                    done_next      = 1'b1;
                end
                if (start) begin
                    neg_q_next = sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r_next = sgn & dividend[WIDTH-1];
                    rem_next   = '0;
                    cnt_next   = '0;
                    dvs_next   = divisor_mag;
                    if (divisor == '0) begin
                        dz_pend_next = 1'b1;
                        quo_next     = dividend;
                    end else begin
                        quo_next   = dividend_mag;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) rem_next = trial[WIDTH-1:0];
                else               rem_next = shifted[WIDTH-1:0];
                quo_next = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                // Truncating division: remainder follows the dividend's sign.
                quotient_next  = neg_q_reg ? -quo_reg : quo_reg;
                remainder_next = neg_r_reg ? -rem_reg : rem_reg;
                dz_next        = 1'b0;
                done_next      = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            dz_pend_reg   <= 1'b0;
            done_reg      <= 1'b0;
            dz_reg        <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            dvs_reg       <= dvs_next;
            neg_q_reg     <= neg_q_next;
            neg_r_reg     <= neg_r_next;
            dz_pend_reg   <= dz_pend_next;
            done_reg      <= done_next;
            dz_reg        <= dz_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: 8-bit instance with a scoreboard,
// 4-bit instance for the latency/busy-width case.
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0] dividend8 = '0, divisor8 = '0;
    logic       busy8, done8, dz8;
    logic [7:0] quotient8, remainder8;

    logic       start4 = 1'b0, sgn4 = 1'b0;
    logic [3:0] dividend4 = '0, divisor4 = '0;
    logic       busy4, done4, dz4;
    logic [3:0] quotient4, remainder4;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;
    exp_t sb_q[$];

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sgn(sgn8),
        .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
        .quotient(quotient8), .remainder(remainder8), .div_by_zero(dz8)
    );

    seq_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sgn(sgn4),
        .dividend(dividend4), .divisor(divisor4), .busy(busy4), .done(done4),
        .quotient(quotient4), .remainder(remainder4), .div_by_zero(dz4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division truncating toward zero.
    function automatic exp_t model8(input logic s, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int sa, sd, q, r;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dz = 1'b1;
        end else begin
            sa = (s && a[7]) ? int'(a) - 256 : int'(a);
            sd = (s && b[7]) ? int'(b) - 256 : int'(b);
            q = sa / sd;
            r = sa % sd;
            e.q = q[7:0]; e.r = r[7:0]; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every done pulse pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            check("done_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("quotient", quotient8, e.q);
                check("remainder", remainder8, e.r);
                check("div_by_zero", dz8, e.dz);
                $display("[TB] result q=0x%02h r=0x%02h dz=%0b", quotient8, remainder8, dz8);
            end
        end
    end

    // One division on the 8-bit unit, with a start pulse injected while busy.
    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b, input int lat);
        int n;
        logic [7:0] qh;
        @(negedge clk);
        sgn8 = s; dividend8 = a; divisor8 = b; start8 = 1'b1;
        sb_q.push_back(model8(s, a, b));
        @(posedge clk); #1;
        start8 = 1'b0;
        check("busy_after_accept", busy8, 32'(b != 8'd0));
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done8) break;
            if (n == 2) begin
                start8 = 1'b1; dividend8 = ~a; divisor8 = 8'd0;
            end else begin
                start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        check("latency", n, lat);
        qh = quotient8;
        @(posedge clk); #1;
        check("done_one_cycle", done8, 1'b0);
        check("result_held", quotient8, qh);
    endtask

    initial begin
        int n, nb, free;
        exp_t e;
        logic s;
        logic [7:0] a, b;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_quotient", quotient8, 8'd0);
        check("rst_remainder", remainder8, 8'd0);
        check("rst_dz", dz8, 1'b0);
        check("rst_busy4", busy4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=4: 13/3, latency and busy width
        @(negedge clk);
        start4 = 1'b1; sgn4 = 1'b0; dividend4 = 4'd13; divisor4 = 4'd3;
        @(posedge clk); #1;
        start4 = 1'b0;
        nb = busy4 ? 1 : 0;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done4) break;
            if (busy4) nb++;
        end
        check("w4_latency", n, 5);
        check("w4_busy_cycles", nb, 5);
        check("w4_quotient", quotient4, 4'd4);
        check("w4_remainder", remainder4, 4'd1);
        check("w4_dz", dz4, 1'b0);
        check("w4_busy_at_done", busy4, 1'b0);

        // WIDTH=8 directed cases
        run8(1'b1, 8'hF9, 8'h02, 9);
        run8(1'b1, 8'h07, 8'hFE, 9);
        run8(1'b0, 8'd200, 8'd0, 1);
        run8(1'b0, 8'd10, 8'd5, 9);
        run8(1'b1, 8'h80, 8'hFF, 9);
        run8(1'b0, 8'd255, 8'd1, 9);
        run8(1'b0, 8'd5, 8'd9, 9);
        run8(1'b1, 8'h80, 8'h00, 1);

        // Back-to-back with start held high and operands changing every cycle
        free = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            sgn8 = s; dividend8 = a; divisor8 = b; start8 = 1'b1;
            check("b2b_busy", busy8, 32'(free != 0));
            if (free == 0) begin
                sb_q.push_back(model8(s, a, b));
                free = (b == 8'd0) ? 0 : 9;
            end else begin
                free--;
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (sb_q.size() > 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("b2b_drained", sb_q.size(), 0);

        // Reset mid-division: no done, outputs cleared
        run8(1'b0, 8'd100, 8'd7, 9);
        @(negedge clk);
        sgn8 = 1'b0; dividend8 = 8'd200; divisor8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy8, 1'b0);
        check("abort_done", done8, 1'b0);
        check("abort_quotient", quotient8, 8'd0);
        check("abort_remainder", remainder8, 8'd0);
        check("abort_dz", dz8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) nb++;
        end
        check("abort_no_done", nb, 0);
        run8(1'b1, 8'hC8, 8'h07, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
